// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: parallel MAC lanes, bias/shift/saturate, serial output.
// Optional ReLU after saturation when DENSE_RELU_EN is defined.
module dense_layer_engine #(
    parameter int DATA_W     = 32,
    parameter int WEIGHT_W   = 32,
    parameter int BIAS_W     = 32,
    parameter int IN_LEN     = 824,
    parameter int NEURON_NUM = 10,
    parameter int ACC_W      = 80,
    parameter int FRAC_SHIFT = 0,
    parameter int OUT_W      = 48,
    localparam int NW = $clog2(NEURON_NUM),
    localparam int IW = $clog2(IN_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_we,
    input  logic [NW-1:0]       w_neuron,
    input  logic [IW-1:0]       w_idx,
    input  logic [WEIGHT_W-1:0] w_data,
    input  logic                b_we,
    input  logic [NW-1:0]       b_neuron,
    input  logic [BIAS_W-1:0]   b_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [NW-1:0]       out_idx,
    output logic                out_last,
    output logic                busy,
    output logic                err_len,
    input  logic                err_clr
);

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DRAIN} state_t;

    localparam int PW = DATA_W + WEIGHT_W;
    localparam logic [IW-1:0] LAST_K = IW'(IN_LEN - 1);
    localparam logic [NW-1:0] LAST_N = NW'(NEURON_NUM - 1);
    localparam logic signed [ACC_W-1:0] OMAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t state, state_nx;

    logic signed [WEIGHT_W-1:0] w_mem  [NEURON_NUM][IN_LEN];
    logic signed [BIAS_W-1:0]   b_mem  [NEURON_NUM];
    logic signed [ACC_W-1:0]    acc    [NEURON_NUM];
    logic signed [OUT_W-1:0]    res    [NEURON_NUM];
    logic signed [PW-1:0]       prod   [NEURON_NUM];
    logic signed [OUT_W-1:0]    res_nx [NEURON_NUM];
    logic signed [ACC_W-1:0]    sum_v;
    logic signed [ACC_W-1:0]    sh_v;

    logic [IW-1:0] cnt;
    logic [NW-1:0] ptr;
    logic          beat;
    logic          hs;
    logic          cfg_ok;
    logic          err_set;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign beat      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign busy      = (state != IDLE) || (cnt != '0);
    assign cfg_ok    = !busy && !beat;
    assign err_set   = beat && (in_last != (cnt == LAST_K));
    assign out_data  = res[ptr];
    assign out_idx   = ptr;
    assign out_last  = out_valid && (ptr == LAST_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (beat) state_nx = ACCUM;
            ACCUM:   if (beat && cnt == LAST_K) state_nx = BIAS;
            BIAS:    state_nx = DRAIN;
            DRAIN:   if (hs && ptr == LAST_N) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum_v = '0;
        sh_v  = '0;
        for (int n = 0; n < NEURON_NUM; n++) begin
            prod[n] = PW'($signed(in_data)) * PW'(w_mem[n][cnt]);
            sum_v   = acc[n] + ACC_W'(b_mem[n]);
            sh_v    = sum_v >>> FRAC_SHIFT;
            if (sh_v > OMAX)      res_nx[n] = OMAX[OUT_W-1:0];
            else if (sh_v < OMIN) res_nx[n] = OMIN[OUT_W-1:0];
            else                  res_nx[n] = sh_v[OUT_W-1:0];
`ifdef DENSE_RELU_EN
            if (res_nx[n][OUT_W-1]) res_nx[n] = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            ptr     <= '0;
            err_len <= 1'b0;
            for (int n = 0; n < NEURON_NUM; n++) begin
                acc[n] <= '0;
                res[n] <= '0;
            end
        end else begin
            if (beat) begin
                cnt <= (cnt == LAST_K) ? '0 : cnt + IW'(1);
                // First beat of a frame restarts every lane from zero
                for (int n = 0; n < NEURON_NUM; n++)
                    acc[n] <= (cnt == '0 ? '0 : acc[n]) + ACC_W'(prod[n]);
            end
            if (state == BIAS) begin
                for (int n = 0; n < NEURON_NUM; n++)
                    res[n] <= res_nx[n];
            end
            if (hs) ptr <= (ptr == LAST_N) ? '0 : ptr + NW'(1);
            if (err_set)      err_len <= 1'b1;
            else if (err_clr) err_len <= 1'b0;
        end
    end

    // Coefficient storage survives reset so a network need not be reloaded
    always_ff @(posedge clk) begin
        if (w_we && cfg_ok && w_idx <= LAST_K && w_neuron <= LAST_N)
            w_mem[w_neuron][w_idx] <= w_data;
        if (b_we && cfg_ok && b_neuron <= LAST_N)
            b_mem[b_neuron] <= b_data;
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: IN_LEN=4, NEURON_NUM=3, OUT_W=8.
// Table vectors feed a scoreboard queue; a monitor pops on each output handshake.
module tb_dense_layer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we, b_we, in_valid, in_last, out_ready, err_clr;
    logic [1:0]  w_neuron, w_idx, b_neuron;
    logic [31:0] w_data, b_data, in_data;
    logic        in_ready, out_valid, out_last, busy, err_len;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;

    always #5 clk = ~clk;

    dense_layer_engine #(
        .DATA_W(32), .WEIGHT_W(32), .BIAS_W(32), .IN_LEN(4),
        .NEURON_NUM(3), .ACC_W(80), .FRAC_SHIFT(0), .OUT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_neuron(w_neuron), .w_idx(w_idx), .w_data(w_data),
        .b_we(b_we), .b_neuron(b_neuron), .b_data(b_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .err_len(err_len), .err_clr(err_clr)
    );

    typedef struct {
        int x[4];
        int w[3][4];
        int b[3];
        int e[3];
    } vec_t;

    typedef struct {
        int d;
        int i;
        bit l;
    } exp_t;

    vec_t tv[5];
    exp_t q[$];
    exp_t me;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    logic held_v = 1'b0;
    int   hd, hi, sd;

    function automatic void chk(string nm, int got, int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", nm, got, exp);
    endfunction

    function automatic int act(int v);
`ifdef DENSE_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            sd = int'($signed(out_data));
            if (held_v && out_valid) begin
                chk("hold_data", sd, hd);
                chk("hold_idx", int'(out_idx), hi);
            end
            if (out_valid) chk("in_ready_drain", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    me = q.pop_front();
                    chk("out_data", sd, me.d);
                    chk("out_idx", int'(out_idx), me.i);
                    chk("out_last", int'(out_last), int'(me.l));
                end
            end
            held_v = out_valid && !out_ready;
            hd = sd;
            hi = int'(out_idx);
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 4; k++) begin
                w_we = 1'b1;
                w_neuron = 2'(n);
                w_idx = 2'(k);
                w_data = tv[v].w[n][k];
                tick();
            end
        end
        w_we = 1'b0;
        for (int n = 0; n < 3; n++) begin
            b_we = 1'b1;
            b_neuron = 2'(n);
            b_data = tv[v].b[n];
            tick();
        end
        b_we = 1'b0;
    endtask

    task automatic push(input int v);
        for (int n = 0; n < 3; n++)
            q.push_back('{act(tv[v].e[n]), n, (n == 2)});
    endtask

    task automatic send(input int v, input int k0, input int k1, input int lastk);
        for (int k = k0; k < k1; k++) begin
            in_valid = 1'b1;
            in_data = tv[v].x[k];
            in_last = (k == lastk);
            chk("in_ready_beat", int'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic latency();
        @(negedge clk);
        chk("lat_bias_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_drain_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int v, input int lastk);
        push(v);
        send(v, 0, 4, lastk);
        latency();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", int'(n < 100), 1);
    endtask

    initial begin
        tv[0] = '{'{1, 2, 3, 4},
                  '{'{1, 1, 1, 1}, '{2, 2, 2, 2}, '{3, 3, 3, 3}},
                  '{0, 10, -100}, '{10, 30, -70}};
        tv[1] = '{'{127, 127, 127, 127},
                  '{'{127, 127, 127, 127}, '{127, 127, 127, 127},
                    '{127, 127, 127, 127}},
                  '{0, 0, 0}, '{127, 127, 127}};
        tv[2] = '{'{127, 127, 127, 127},
                  '{'{-127, -127, -127, -127}, '{-127, -127, -127, -127},
                    '{-127, -127, -127, -127}},
                  '{0, 0, 0}, '{-128, -128, -128}};
        tv[3] = '{'{0, 0, 0, 0},
                  '{'{-127, -127, -127, -127}, '{-127, -127, -127, -127},
                    '{-127, -127, -127, -127}},
                  '{0, 0, -100}, '{0, 0, -100}};
        tv[4] = '{'{-3, 5, 0, 2},
                  '{'{1, 1, 1, 1}, '{2, -1, 7, 3}, '{-10, -10, -10, -10}},
                  '{1, 2, 3}, '{5, -3, -37}};

        rst = 1'b1;
        w_we = 1'b0; b_we = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        w_neuron = '0; w_idx = '0; b_neuron = '0;
        w_data = '0; b_data = '0; in_data = '0;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_len", int'(err_len), 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            load(v);
            frame(v, 3);
            drain();
            chk("clean_err_len", int'(err_len), 0);
        end

        // Back-pressure: stall 5 cycles, then toggle out_ready
        load(0);
        out_ready = 1'b0;
        frame(0, 3);
        repeat (3) tick();
        for (int i = 0; i < 40 && (q.size() != 0 || busy); i++) begin
            out_ready = i[0];
            tick();
        end
        out_ready = 1'b1;
        drain();

        // in_last on beat 1 instead of beat 3
        load(4);
        frame(4, 1);
        chk("err_set", int'(err_len), 1);
        drain();
        chk("err_sticky", int'(err_len), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", int'(err_len), 0);

        // Abort mid-frame, then a clean frame
        send(4, 0, 2, 3);
        chk("busy_mid", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        tick();
        frame(4, 3);
        drain();

        // Coefficient writes while busy or alongside a beat are dropped
        push(4);
        in_valid = 1'b1;
        in_data = tv[4].x[0];
        in_last = 1'b0;
        w_we = 1'b1; w_neuron = 2'd0; w_idx = 2'd0; w_data = 32'd99;
        tick();
        w_we = 1'b0;
        send(4, 1, 4, 3);
        w_we = 1'b1; w_neuron = 2'd1; w_idx = 2'd1; w_data = 32'd55;
        b_we = 1'b1; b_neuron = 2'd2; b_data = 32'd77;
        tick();
        w_we = 1'b0;
        b_we = 1'b0;
        drain();
        frame(4, 3);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 required 0");
        $fatal(1, "timeout");
    end

endmodule
